// File: rtl/count_checker.sv
// ---------------------------------------------------------------------------
// count_checker
//
// Watches the output of a free-running WIDTH-bit up-counter and checks that
// every sampled value is exactly one more (mod 2^WIDTH) than the previous one.
// The checker first synchronises to the stream: two consecutive correct
// increments take it into LOCK. While locked, any repeated or skipped value
// is a mismatch. Enough mismatches drive it into a sticky FAIL state.
//
// Parameters
//   WIDTH      width of the checked count bus
//   ERR_LIMIT  mismatch count at which the checker enters FAIL
//
// Ports
//   clk         rising-edge clock for all state
//   reset       asynchronous, active-low reset (0 = in reset)
//   count_in    count value produced by the counter under check
//   valid       count_in is sampled on a rising edge where valid=1
//   clr         synchronous clear of state and statistics (beats valid)
//   locked      high while the checker is in LOCK
//   err         one-cycle pulse per detected mismatch
//   err_count   number of mismatches, saturating at 255
//   wrap_count  counter wraps seen while locked, modulo 256
//   fail        sticky failure flag, high in FAIL
//
// Every output is a flop, so the effect of a sample is visible one cycle
// after the edge that took it.
// ---------------------------------------------------------------------------
module count_checker #(
    parameter int WIDTH     = 3,
    parameter int ERR_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count_in,
    input  logic             valid,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_count,
    output logic [7:0]       wrap_count,
    output logic             fail
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LOCK,
        ST_FAIL
    } state_t;

    // ERR_LIMIT compared on a 32-bit unsigned basis. Any limit above 255 is
    // unreachable because err_count saturates, which is the intended
    // behaviour: such a checker never fails.
    localparam logic [31:0] ERR_LIMIT_U = 32'(ERR_LIMIT);

    // Value that marks the top of the count range; a matched sample of this
    // value in LOCK means the counter under check is about to wrap.
    localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] expected_q;
    logic [WIDTH-1:0] expected_d;
    logic             match_run_q;
    logic             match_run_d;
    logic [7:0]       err_count_d;
    logic [7:0]       wrap_count_d;
    logic             err_d;
    logic             locked_d;
    logic             fail_d;

    logic             sample_match;
    logic [WIDTH-1:0] count_plus_one;
    logic [WIDTH-1:0] expected_plus_one;
    logic [7:0]       err_count_inc;
    logic             limit_hit;

    // Shared arithmetic used by several FSM branches. The increments wrap
    // naturally at the register width; err_count_inc holds at 255 so the
    // statistic never rolls over back to a small number.
    always_comb begin
        sample_match      = (count_in == expected_q);
        count_plus_one    = count_in + 1'b1;
        expected_plus_one = expected_q + 1'b1;
        err_count_inc     = (err_count == 8'hFF) ? 8'hFF : (err_count + 8'd1);
        limit_hit         = ({24'd0, err_count_inc} == ERR_LIMIT_U);
    end

    // Next-state and next-output logic. Everything holds by default so a
    // cycle with valid=0 leaves the checker untouched and err low. clr is
    // handled first so it wins over a coincident sample. In SYNC a mismatch
    // only resynchronises; it is not an error because the checker has not
    // yet claimed the stream is well formed. In LOCK a mismatch counts,
    // and the mismatching value becomes the new reference so that a counter
    // that simply jumped can be re-acquired after two good increments.
    always_comb begin
        state_d      = state_q;
        expected_d   = expected_q;
        match_run_d  = match_run_q;
        err_count_d  = err_count;
        wrap_count_d = wrap_count;
        err_d        = 1'b0;

        if (clr) begin
            state_d      = ST_IDLE;
            expected_d   = '0;
            match_run_d  = 1'b0;
            err_count_d  = 8'd0;
            wrap_count_d = 8'd0;
        end else if (valid) begin
            case (state_q)
                ST_IDLE: begin
                    expected_d  = count_plus_one;
                    match_run_d = 1'b0;
                    state_d     = ST_SYNC;
                end

                ST_SYNC: begin
                    if (sample_match) begin
                        expected_d = expected_plus_one;
                        if (match_run_q) begin
                            match_run_d = 1'b0;
                            state_d     = ST_LOCK;
                        end else begin
                            match_run_d = 1'b1;
                        end
                    end else begin
                        expected_d  = count_plus_one;
                        match_run_d = 1'b0;
                    end
                end

                ST_LOCK: begin
                    if (sample_match) begin
                        expected_d = expected_plus_one;
                        if (count_in == COUNT_MAX) begin
                            wrap_count_d = wrap_count + 8'd1;
                        end
                    end else begin
                        err_d       = 1'b1;
                        err_count_d = err_count_inc;
                        expected_d  = count_plus_one;
                        match_run_d = 1'b0;
                        state_d     = limit_hit ? ST_FAIL : ST_SYNC;
                    end
                end

                ST_FAIL: begin
                    state_d = ST_FAIL;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCK);
        fail_d   = (state_d == ST_FAIL);
    end

    // State and output registers. Reset is asynchronous so the outputs clear
    // the moment reset is asserted, without needing a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            expected_q  <= '0;
            match_run_q <= 1'b0;
            err_count   <= 8'd0;
            wrap_count  <= 8'd0;
            err         <= 1'b0;
            locked      <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            match_run_q <= match_run_d;
            err_count   <= err_count_d;
            wrap_count  <= wrap_count_d;
            err         <= err_d;
            locked      <= locked_d;
            fail        <= fail_d;
        end
    end

endmodule

// File: tb/tb_count_checker.sv
// ---------------------------------------------------------------------------
// tb_count_checker
//
// Directed bench for count_checker (WIDTH=3, ERR_LIMIT=4). Each stimulus
// cycle pushes its hand-computed expected outputs into a scoreboard queue;
// a monitor pops one entry after every rising edge and compares it with
// the registered outputs. Asynchronous reset is checked directly between
// clock edges.
// ---------------------------------------------------------------------------
module tb_count_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] count_in = 3'd0;
    logic       valid = 1'b0;
    logic       clr = 1'b0;
    logic       locked;
    logic       err;
    logic [7:0] err_count;
    logic [7:0] wrap_count;
    logic       fail;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic       locked;
        logic       err;
        logic [7:0] ec;
        logic [7:0] wc;
        logic       fail;
    } exp_t;

    exp_t sb_q[$];

    count_checker #(
        .WIDTH(3),
        .ERR_LIMIT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .count_in(count_in),
        .valid(valid),
        .clr(clr),
        .locked(locked),
        .err(err),
        .err_count(err_count),
        .wrap_count(wrap_count),
        .fail(fail)
    );

    // 10 ns clock: rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drive one sample on the falling edge and queue what the outputs must
    // look like after the following rising edge.
    task automatic applyStimulus(input string name, input logic v, input logic [2:0] c,
                                 input logic cl, input logic e_locked, input logic e_err,
                                 input logic [7:0] e_ec, input logic [7:0] e_wc,
                                 input logic e_fail);
        exp_t e;
        @(negedge clk);
        valid    = v;
        count_in = c;
        clr      = cl;
        e.name   = name;
        e.locked = e_locked;
        e.err    = e_err;
        e.ec     = e_ec;
        e.wc     = e_wc;
        e.fail   = e_fail;
        sb_q.push_back(e);
    endtask

    // Monitor: one scoreboard entry per rising edge, sampled 1 ns later.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (reset && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checkOutput({e.name, ".locked"}, {7'd0, locked}, {7'd0, e.locked});
            checkOutput({e.name, ".err"}, {7'd0, err}, {7'd0, e.err});
            checkOutput({e.name, ".err_count"}, err_count, e.ec);
            checkOutput({e.name, ".wrap_count"}, wrap_count, e.wc);
            checkOutput({e.name, ".fail"}, {7'd0, fail}, {7'd0, e.fail});
        end
    end

    task automatic checkAllClear(input string name);
        checkOutput({name, ".locked"}, {7'd0, locked}, 8'd0);
        checkOutput({name, ".err"}, {7'd0, err}, 8'd0);
        checkOutput({name, ".err_count"}, err_count, 8'd0);
        checkOutput({name, ".wrap_count"}, wrap_count, 8'd0);
        checkOutput({name, ".fail"}, {7'd0, fail}, 8'd0);
    endtask

    initial begin
        int budget;

        // Asynchronous reset at t=1, checked at t=2 before any clock edge.
        #1 reset = 1'b0;
        #1 checkAllClear("reset_async_initial");
        @(negedge clk);
        reset = 1'b1;

        // Acquire lock on 5,6,7.
        applyStimulus("lock_5", 1, 3'd5, 0, 0, 0, 0, 0, 0);
        applyStimulus("lock_6", 1, 3'd6, 0, 0, 0, 0, 0, 0);
        applyStimulus("lock_7", 1, 3'd7, 0, 1, 0, 0, 0, 0);

        // Locked run up to 6, then 7 wraps, then 0,1.
        for (int i = 0; i < 7; i++) begin
            applyStimulus("run", 1, 3'(i), 0, 1, 0, 0, 0, 0);
        end
        applyStimulus("wrap_7", 1, 3'd7, 0, 1, 0, 0, 1, 0);
        applyStimulus("wrap_0", 1, 3'd0, 0, 1, 0, 0, 1, 0);
        applyStimulus("wrap_1", 1, 3'd1, 0, 1, 0, 0, 1, 0);

        // Skip 4: one error pulse, resync on 6,7.
        applyStimulus("mm_2", 1, 3'd2, 0, 1, 0, 0, 1, 0);
        applyStimulus("mm_3", 1, 3'd3, 0, 1, 0, 0, 1, 0);
        applyStimulus("mm_5", 1, 3'd5, 0, 0, 1, 1, 1, 0);
        applyStimulus("mm_6", 1, 3'd6, 0, 0, 0, 1, 1, 0);
        applyStimulus("mm_7", 1, 3'd7, 0, 1, 0, 1, 1, 0);

        // Gaps: valid low cycles change nothing.
        applyStimulus("gap_0", 1, 3'd0, 0, 1, 0, 1, 1, 0);
        applyStimulus("gap_1", 1, 3'd1, 0, 1, 0, 1, 1, 0);
        applyStimulus("gap_x1", 0, 3'd5, 0, 1, 0, 1, 1, 0);
        applyStimulus("gap_x2", 0, 3'd3, 0, 1, 0, 1, 1, 0);
        applyStimulus("gap_2", 1, 3'd2, 0, 1, 0, 1, 1, 0);

        // Stall (repeat of 2) is a mismatch.
        applyStimulus("stall_2", 1, 3'd2, 0, 0, 1, 2, 1, 0);
        applyStimulus("stall_idle", 0, 3'd0, 0, 0, 0, 2, 1, 0);

        // Relock and drive err_count to the limit.
        applyStimulus("f_3", 1, 3'd3, 0, 0, 0, 2, 1, 0);
        applyStimulus("f_4", 1, 3'd4, 0, 1, 0, 2, 1, 0);
        applyStimulus("f_skip6", 1, 3'd6, 0, 0, 1, 3, 1, 0);
        applyStimulus("f_7", 1, 3'd7, 0, 0, 0, 3, 1, 0);
        applyStimulus("f_0", 1, 3'd0, 0, 1, 0, 3, 1, 0);
        applyStimulus("f_1", 1, 3'd1, 0, 1, 0, 3, 1, 0);
        applyStimulus("f_stall1", 1, 3'd1, 0, 0, 1, 4, 1, 1);
        applyStimulus("f_hold2", 1, 3'd2, 0, 0, 0, 4, 1, 1);
        applyStimulus("f_hold3", 1, 3'd3, 0, 0, 0, 4, 1, 1);

        // clr from FAIL (with valid high) clears everything.
        applyStimulus("clr_fail", 1, 3'd5, 1, 0, 0, 0, 0, 0);
        applyStimulus("cl_5", 1, 3'd5, 0, 0, 0, 0, 0, 0);
        applyStimulus("cl_6", 1, 3'd6, 0, 0, 0, 0, 0, 0);
        applyStimulus("cl_7", 1, 3'd7, 0, 1, 0, 0, 0, 0);

        // clr beats valid: the 0 is ignored, lock needs 1,2,3 from IDLE.
        applyStimulus("clr_pri", 1, 3'd0, 1, 0, 0, 0, 0, 0);
        applyStimulus("pri_1", 1, 3'd1, 0, 0, 0, 0, 0, 0);
        applyStimulus("pri_2", 1, 3'd2, 0, 0, 0, 0, 0, 0);
        applyStimulus("pri_3", 1, 3'd3, 0, 1, 0, 0, 0, 0);
        applyStimulus("pri_4", 1, 3'd4, 0, 1, 0, 0, 0, 0);
        applyStimulus("pri_5", 1, 3'd5, 0, 1, 0, 0, 0, 0);
        applyStimulus("pri_6", 1, 3'd6, 0, 1, 0, 0, 0, 0);
        applyStimulus("pri_7", 1, 3'd7, 0, 1, 0, 0, 1, 0);

        // Async reset while locked with wrap_count=1, between edges.
        @(posedge clk);
        #2;
        valid = 1'b0;
        reset = 1'b0;
        #1 checkAllClear("reset_async_locked");
        @(negedge clk);
        reset = 1'b1;

        // State was discarded: 5 starts a fresh sync, no error.
        applyStimulus("post_5", 1, 3'd5, 0, 0, 0, 0, 0, 0);
        applyStimulus("post_6", 1, 3'd6, 0, 0, 0, 0, 0, 0);
        applyStimulus("post_7", 1, 3'd7, 0, 1, 0, 0, 0, 0);
        applyStimulus("post_idle", 0, 3'd0, 0, 1, 0, 0, 0, 0);

        // Let the monitor drain the scoreboard, bounded.
        budget = 0;
        while (sb_q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        #2;
        checkOutput("drain", 8'(sb_q.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
